// File: rtl/capture_ctrl.sv
// rtl/capture_ctrl.sv - probe sampler that packs 16 samples per word into a capture RAM
//
// Ports:
//   clk        single clock, all state changes on its rising edge
//   resetn     asynchronous active-low reset
//   probe      asynchronous signal under capture (synchronized internally)
//   arm        one-cycle start pulse, honoured only from IDLE or DONE
//   abort      one-cycle stop pulse, wins over everything else
//   trig_en    0: capture starts on arm, 1: wait in ARMED for a probe edge
//   trig_fall  edge select while ARMED: 0 rising, 1 falling
//   div        sample period minus one, latched when a capture is armed
//   wr_en      registered one-cycle write strobe per packed word
//   wr_addr    RAM word address for the current wr_en
//   wr_data    registered packed word, earliest sample in bit 0
//   busy       high in ARMED or CAPTURE
//   done       high in DONE, buffer full
module capture_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DIV_W  = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              probe,
    input  logic              arm,
    input  logic              abort,
    input  logic              trig_en,
    input  logic              trig_fall,
    input  logic [DIV_W-1:0]  div,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic              r_sync1;
    logic              r_ps;
    logic              r_ps_d;
    logic [DIV_W-1:0]  r_div;
    logic [DIV_W-1:0]  r_divcnt;
    logic [3:0]        r_bitcnt;
    logic [15:0]       r_shift;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [15:0]       r_wr_data;

    logic w_start;
    logic w_edge;
    logic w_tick;
    logic w_word;
    logic w_last;

    always_comb begin
        w_start = arm && ((r_state == S_IDLE) || (r_state == S_DONE));
        w_edge  = trig_fall ? (~r_ps & r_ps_d) : (r_ps & ~r_ps_d);
        w_tick  = (r_state == S_CAPTURE) && (r_divcnt == r_div);
        w_word  = w_tick && (r_bitcnt == 4'd15);
        // The final word's strobe is on the bus this cycle; leave CAPTURE
        // now so done appears the cycle after the strobe.
        w_last  = r_wr_en && (r_wr_addr == {ADDR_W{1'b1}});
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        if (abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (arm) begin
                        w_next = trig_en ? S_ARMED : S_CAPTURE;
                    end
                end
                S_ARMED: begin
                    if (w_edge) begin
                        w_next = S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (w_last) begin
                        w_next = S_DONE;
                    end
                end
                default: w_next = S_IDLE;
            endcase
        end
        case (r_state)
            S_ARMED, S_CAPTURE: busy = 1'b1;
            S_DONE:             done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync1   <= 1'b0;
            r_ps      <= 1'b0;
            r_ps_d    <= 1'b0;
            r_div     <= '0;
            r_divcnt  <= '0;
            r_bitcnt  <= '0;
            r_shift   <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_sync1 <= probe;
            r_ps    <= r_sync1;
            r_ps_d  <= r_ps;

            // An abort on the 16th tick discards that word as well.
            r_wr_en <= w_word && !abort;
            if (w_word && !abort) begin
                r_wr_data <= {r_ps, r_shift[15:1]};
            end

            if (w_start && !abort) begin
                r_div     <= div;
                r_bitcnt  <= '0;
                r_wr_addr <= '0;
                // Entering CAPTURE directly: preload so the first cycle ticks.
                r_divcnt  <= trig_en ? '0 : div;
            end else begin
                // Address advances the cycle after the strobe; naturally
                // wraps to 0 after the last word.
                if (r_wr_en) begin
                    r_wr_addr <= r_wr_addr + 1'b1;
                end
                if ((r_state == S_ARMED) && w_edge) begin
                    r_divcnt <= r_div;
                end else if (w_tick) begin
                    r_divcnt <= '0;
                    r_shift  <= {r_ps, r_shift[15:1]};
                    r_bitcnt <= r_bitcnt + 4'd1;
                end else if (r_state == S_CAPTURE) begin
                    r_divcnt <= r_divcnt + 1'b1;
                end
            end
        end
    end

    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;

endmodule

// File: tb/tb_capture_ctrl.sv
// tb/tb_capture_ctrl.sv - directed bench with timing-arithmetic model for capture_ctrl
module tb_capture_ctrl;

    localparam int AW  = 2;
    localparam int DW  = 8;
    localparam int NW  = 4;
    localparam int HSZ = 8192;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          arm = 1'b0;
    logic          abort = 1'b0;
    logic          trig_en = 1'b0;
    logic          trig_fall = 1'b0;
    logic          probe_drv = 1'b0;
    logic          tog_en = 1'b0;
    logic          tog_val;
    logic          probe;
    logic [DW-1:0] div = '0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;
    logic          busy;
    logic          done;

    int n_vec = 0;
    int n_miss = 0;
    int cyc = 0;
    int tog_cnt;
    logic stim_done = 1'b0;

    // Input values as seen at each rising edge (index = edge number).
    logic          h_probe [0:HSZ-1];
    logic          h_arm   [0:HSZ-1];
    logic          h_abort [0:HSZ-1];
    logic          h_trig  [0:HSZ-1];
    logic          h_fall  [0:HSZ-1];
    logic [DW-1:0] h_div   [0:HSZ-1];

    // Scenario model: capture start edge S, tick edges S+1+j*(div+1),
    // each tick stores the probe value seen two edges earlier.
    logic        m_active, m_done, m_wr, m_pend, m_bb;
    int          m_addr, m_words, m_div, m_S, m_d, m_k, m_e;
    logic [15:0] m_data, m_acc;

    assign probe = tog_en ? tog_val : probe_drv;

    capture_ctrl #(.ADDR_W(AW), .DIV_W(DW)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .probe     (probe),
        .arm       (arm),
        .abort     (abort),
        .trig_en   (trig_en),
        .trig_fall (trig_fall),
        .div       (div),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cyc < HSZ - 2) begin
            h_probe[cyc+1] <= probe;
            h_arm[cyc+1]   <= arm;
            h_abort[cyc+1] <= abort;
            h_trig[cyc+1]  <= trig_en;
            h_fall[cyc+1]  <= trig_fall;
            h_div[cyc+1]   <= div;
        end
        cyc <= cyc + 1;
    end

    // Probe toggles every 4 clocks while tog_en is set.
    initial begin
        tog_val = 1'b0;
        tog_cnt = 0;
        forever begin
            @(posedge clk);
            #2;
            if (tog_en) begin
                if (tog_cnt == 3) begin
                    tog_cnt = 0;
                    tog_val = ~tog_val;
                end else begin
                    tog_cnt = tog_cnt + 1;
                end
            end else begin
                tog_cnt = 0;
            end
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_miss = n_miss + 1;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_wr(input string nm, output int n);
        n = 0;
        do begin
            @(posedge clk);
            n = n + 1;
            #1;
        end while (!wr_en && n < 500);
        if (!wr_en) begin
            n_vec = n_vec + 1;
            n_miss = n_miss + 1;
            $display("FAIL %s: no wr_en within %0d cycles", nm, n);
        end
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        @(posedge clk);
        #2;
        arm = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        @(posedge clk);
        #2;
        abort = 1'b0;
    endtask

    task automatic count_wr(input int cycles, output int cnt);
        cnt = 0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            if (wr_en) cnt = cnt + 1;
        end
    endtask

    initial begin
        m_active = 0; m_done = 0; m_wr = 0; m_pend = 0; m_bb = 0;
        m_addr = 0; m_words = 0; m_div = 0; m_S = -1;
        m_data = '0; m_acc = '0;
        fork
            begin : compare
                while (!stim_done) begin
                    @(negedge clk);
                    m_e = cyc;
                    if (!resetn) begin
                        m_active = 0; m_done = 0; m_wr = 0; m_pend = 0;
                        m_addr = 0; m_words = 0; m_data = '0;
                    end else if (m_e >= 1) begin
                        m_wr = 0;
                        m_bb = m_active;
                        if (m_pend) begin
                            m_pend = 0;
                            m_addr = (m_addr + 1) % NW;
                            m_words = m_words + 1;
                            if (m_words == NW && m_active) begin
                                m_active = 0;
                                m_done = 1;
                            end
                        end
                        if (h_abort[m_e]) begin
                            m_active = 0;
                            m_done = 0;
                        end else if (h_arm[m_e] && !m_bb) begin
                            m_active = 1; m_done = 0; m_addr = 0; m_words = 0;
                            m_div = int'(h_div[m_e]);
                            m_S = h_trig[m_e] ? -1 : m_e;
                        end else if (m_active) begin
                            if (m_S < 0) begin
                                if (m_e >= 3 &&
                                    ((!h_fall[m_e] && h_probe[m_e-2] && !h_probe[m_e-3]) ||
                                     (h_fall[m_e] && !h_probe[m_e-2] && h_probe[m_e-3])))
                                    m_S = m_e;
                            end else begin
                                m_d = m_e - m_S - 1;
                                if (m_d >= 0 && (m_d % (m_div + 1)) == 0) begin
                                    m_k = m_d / (m_div + 1);
                                    m_acc[m_k % 16] = h_probe[m_e-2];
                                    if ((m_k % 16) == 15) begin
                                        m_wr = 1;
                                        m_pend = 1;
                                        m_data = m_acc;
                                    end
                                end
                            end
                        end
                    end
                    if (m_e >= 1) begin
                        n_vec = n_vec + 1;
                        if (wr_en !== m_wr || int'(wr_addr) !== m_addr || wr_data !== m_data ||
                            busy !== m_active || done !== m_done) begin
                            n_miss = n_miss + 1;
                            $display("FAIL cycle %0d outputs: got wr_en=%b addr=%0d data=%h busy=%b done=%b, expected wr_en=%b addr=%0d data=%h busy=%b done=%b",
                                     m_e, wr_en, wr_addr, wr_data, busy, done,
                                     m_wr, m_addr, m_data, m_active, m_done);
                        end
                    end
                end
            end
            begin : stimulus
                int n, cnt, d0;
                // Reset state
                @(posedge clk);
                #1;
                check("rst_wr_en", int'(wr_en), 0);
                check("rst_wr_addr", int'(wr_addr), 0);
                check("rst_wr_data", int'(wr_data), 0);
                check("rst_busy", int'(busy), 0);
                check("rst_done", int'(done), 0);
                repeat (3) @(posedge clk);
                #2;
                resetn = 1'b1;

                // Free-running capture, div=0, probe high, full buffer
                probe_drv = 1'b1;
                trig_en = 1'b0;
                div = 8'd0;
                repeat (4) @(posedge clk);
                #2;
                pulse_arm();
                check("t1_busy", int'(busy), 1);
                for (int w = 0; w < NW; w++) begin
                    wait_wr("t1_wait", n);
                    check("t1_gap", n, 16);
                    check("t1_addr", int'(wr_addr), w);
                    check("t1_data", int'(wr_data), 16'hFFFF);
                end
                @(posedge clk);
                #1;
                check("t1_done", int'(done), 1);
                check("t1_addr_wrap", int'(wr_addr), 0);
                check("t1_busy_off", int'(busy), 0);
                pulse_arm();
                check("t1_rearm_done_clr", int'(done), 0);
                wait_wr("t1_rerun_wait", n);
                check("t1_rerun_gap", n, 16);
                check("t1_rerun_addr", int'(wr_addr), 0);
                repeat (3) @(posedge clk);
                #2;
                pulse_abort();
                check("t1_abort_busy", int'(busy), 0);

                // Abort on the 10th sample of the second word
                pulse_arm();
                repeat (25) @(posedge clk);
                #2;
                pulse_abort();
                check("t2_busy", int'(busy), 0);
                check("t2_done", int'(done), 0);
                check("t2_addr", int'(wr_addr), 1);
                count_wr(40, cnt);
                check("t2_no_wr", cnt, 0);
                // arm and abort together from IDLE
                #1;
                arm = 1'b1;
                abort = 1'b1;
                @(posedge clk);
                #2;
                arm = 1'b0;
                abort = 1'b0;
                check("t2_arm_abort_busy", int'(busy), 0);
                repeat (10) @(posedge clk);
                #2;
                check("t2_still_idle", int'(busy), 0);

                // div=3 with probe toggling every 4 clocks
                div = 8'd3;
                tog_en = 1'b1;
                repeat (8) @(posedge clk);
                #2;
                pulse_arm();
                wait_wr("t3_wait", n);
                check("t3_first", n, 61);
                d0 = int'(wr_data);
                check("t3_pattern", int'(d0 == 16'h5555 || d0 == 16'hAAAA), 1);
                for (int w = 1; w < NW; w++) begin
                    wait_wr("t3_wait", n);
                    check("t3_gap", n, 64);
                    check("t3_data", int'(wr_data), d0);
                end
                @(posedge clk);
                #1;
                check("t3_done", int'(done), 1);
                tog_en = 1'b0;

                // Rising-edge trigger after 100 cycles of low probe
                div = 8'd0;
                probe_drv = 1'b0;
                trig_en = 1'b1;
                trig_fall = 1'b0;
                repeat (6) @(posedge clk);
                #2;
                pulse_arm();
                count_wr(100, cnt);
                check("t4_armed_no_wr", cnt, 0);
                check("t4_armed_busy", int'(busy), 1);
                #1;
                probe_drv = 1'b1;
                wait_wr("t4_wait", n);
                check("t4_latency", n, 19);
                check("t4_data", int'(wr_data), 16'hFFFF);
                #1;
                pulse_abort();

                // Falling-edge trigger
                trig_fall = 1'b1;
                repeat (6) @(posedge clk);
                #2;
                pulse_arm();
                repeat (10) @(posedge clk);
                #2;
                check("t5_armed_busy", int'(busy), 1);
                probe_drv = 1'b0;
                wait_wr("t5_wait", n);
                check("t5_latency", n, 19);
                check("t5_data", int'(wr_data), 16'h0000);
                #1;
                pulse_abort();
                trig_fall = 1'b0;

                // Reset mid-capture
                trig_en = 1'b0;
                probe_drv = 1'b1;
                repeat (4) @(posedge clk);
                #2;
                pulse_arm();
                repeat (20) @(posedge clk);
                #2;
                resetn = 1'b0;
                #1;
                check("t6_wr_en", int'(wr_en), 0);
                check("t6_wr_addr", int'(wr_addr), 0);
                check("t6_wr_data", int'(wr_data), 0);
                check("t6_busy", int'(busy), 0);
                check("t6_done", int'(done), 0);
                repeat (3) @(posedge clk);
                #2;
                resetn = 1'b1;
                count_wr(30, cnt);
                check("t6_no_wr", cnt, 0);
                check("t6_idle", int'(busy), 0);

                repeat (2) @(posedge clk);
                stim_done = 1'b1;
            end
        join
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
